mandel_scheduler: RTL and testbench
===================================

# mandel_scheduler

Frame-level scheduler that shares a bank of N_LANES Mandelbrot iterator lanes across the pixels of one frame. It walks the screen in raster order, generating each pixel's 4.23 complex constant from a start point and per-pixel step. Each pixel is dispatched to a free lane; finished results are collected in whatever order lanes complete. Each result is written, tagged with its pixel address, to the frame-buffer write port. The block sits between the host/config logic and the iterator bank.

## Interface
- N_LANES, 4: number of iterator lanes (1–16).
- H_RES, 640: pixels per row.
- V_RES, 480: rows per frame.
- ADDR_W, 19: frame-buffer address width; must satisfy ≥ clog2(H_RES*V_RES).
- ITER_W, 11: iteration-count width, equal to clog2(1000)+1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle frame start; ignored unless idle.
- x_start, y_start  in  27  signed 4.23 constant for pixel (0,0): real part and imaginary part.
- dx, dy  in  27  signed 4.23 step per column and per row.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse once the last pixel is written.
- lane_in_val  out  N_LANES  per-lane dispatch strobe.
- lane_c_r, lane_c_i  out  27*N_LANES  per-lane constant; lane k occupies bits [27k+26:27k].
- lane_in_rdy  in  N_LANES  lane idle.
- lane_out_val  in  N_LANES  lane result valid.
- lane_iter_count  in  ITER_W*N_LANES  per-lane result.
- lane_out_rdy  out  N_LANES  per-lane result acknowledge.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  pixel address, computed as y*H_RES + x.
- wr_data  out  ITER_W  iteration count.
- wr_rdy  in  1  frame buffer can accept a write this cycle.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on start; start latches all four coordinate inputs.
  - RUN → DRAIN once the last pixel (H_RES-1, V_RES-1) is dispatched.
  - DRAIN → IDLE once all lane_busy bits are clear and the final write has issued; done pulses in the cycle that IDLE is entered.
- Coordinate generator:
  - Registers x, y, pixel address, cur_r and cur_i.
  - Per dispatch: x += 1 and cur_r += dx.
  - At x = H_RES-1 the row wraps: x = 0, cur_r = x_start, y += 1, cur_i -= dy. The top row uses y_start and imaginary values decrease downward.
  - Arithmetic is 27-bit two's-complement and wraps with no saturation.
- Dispatch:
  - Condition: in RUN, the lowest-index lane k with lane_in_rdy[k] && !lane_busy[k].
  - Action: lane_in_val[k]=1 for exactly one cycle, with lane_c_r/lane_c_i slice k set to cur_r/cur_i.
  - At the clock edge, set lane_busy[k] and store the pixel address in tag[k].
  - At most one dispatch per cycle.
- Collection:
  - Round-robin over lanes with lane_out_val && lane_busy, starting after the last-served lane.
  - When wr_rdy=1, the selected lane j gets lane_out_rdy[j]=1 and wr_en=1, wr_addr=tag[j], wr_data=lane_iter_count slice j, all in the same cycle. lane_busy[j] clears at the edge.
  - At most one collection per cycle.
  - When wr_rdy=0: wr_en=0, lane_out_rdy=0, and results wait in their lanes.
- Simultaneous events:
  - Dispatch and collection may occur in the same cycle on different lanes.
  - A lane collected in cycle t is not eligible for dispatch before cycle t+1 and must also show lane_in_rdy.
- start while busy: ignored, with no effect on latched coordinates.
- Reset (any time, including mid-frame):
  - State goes to IDLE and lane_busy/tags/counters clear.
  - busy=0, done=0, lane_in_val=0, lane_out_rdy=0, wr_en=0, wr_addr=0, wr_data=0.
  - Lanes are reset by the same reset, so in-flight pixels are discarded.

## Timing
- start sampled at edge 0 → RUN and busy=1 from cycle 1; the first lane_in_val can appear in cycle 1.
- Pipeline fill: one new pixel per cycle while free lanes exist.
- Collection: wr_en can occur in the first cycle lane_out_val is seen and wr_rdy=1, with zero added latency.
- done: one cycle after the final wr_en, provided no lanes are busy.
- Total writes per frame: exactly H_RES*V_RES, each address written once.

## Structure
- Shared package mandel_pkg holds FIX_W=27, FRAC_W=23, ITER_MAX=1000, ITER_W, and the state enum.
- Sub-module rr_arbiter (N-way round-robin, grant one-hot, advance-on-accept) is used for collection. Dispatch uses a plain priority encoder inline.

## Test plan
- N_LANES=2, H_RES=4, V_RES=2, x_start=-2.0 (27'h7000000), dx=0.5 (27'h0400000), y_start=0, dy=0 → 8 writes to addresses 0–7, each once. Pixel 1 dispatched with c_r=27'h7400000; wr_data matches the golden iterator model; done is one cycle after the last write.
- All-zero constants (x_start=dx=y_start=dy=0), N_LANES=4, 16×1 frame → every wr_data=1000 and all lanes are concurrently busy.
- wr_rdy held low 50 cycles mid-frame → no wr_en and no lane_out_rdy during the hold. Dispatch stalls once all lanes are busy, and no results are lost after release.
- Row wrap, H_RES=3: third dispatch has x=2; the fourth has c_r=x_start and c_i=y_start-dy.
- Reset asserted with 3 lanes busy → next cycle all outputs are zero and busy=0. A new start then produces a full correct frame.
- start pulsed while busy with different x_start → no effect on the frame; done fires exactly once.

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared constants and FSM state encoding for the Mandelbrot frame scheduler.
package mandel_pkg;

  localparam int FIX_W    = 27;
  localparam int FRAC_W   = 23;
  localparam int ITER_MAX = 1000;
  localparam int ITER_W   = $clog2(ITER_MAX) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter, one-hot grant in the same cycle as req.
// Priority starts just after the last accepted grant; the pointer only moves when accept is high.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last;
  logic [PW-1:0] pick;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    pick  = last;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(last) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        pick       = idx;
      end
    end
  end

  // Reset pointer to the top lane so lane 0 has first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= PW'(N - 1);
    end else if (accept && found) begin
      last <= pick;
    end
  end

endmodule

// File: rtl/mandel_scheduler.sv
// Raster-order pixel dispatcher over N_LANES iterator lanes; dispatch and collection are same-cycle
// combinational handshakes, results stall in their lanes while wr_rdy is low.
module mandel_scheduler
  import mandel_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int ITER_W  = mandel_pkg::ITER_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [FIX_W-1:0]            x_start,
  input  logic [FIX_W-1:0]            y_start,
  input  logic [FIX_W-1:0]            dx,
  input  logic [FIX_W-1:0]            dy,
  output logic                        busy,
  output logic                        done,
  output logic [N_LANES-1:0]          lane_in_val,
  output logic [FIX_W*N_LANES-1:0]    lane_c_r,
  output logic [FIX_W*N_LANES-1:0]    lane_c_i,
  input  logic [N_LANES-1:0]          lane_in_rdy,
  input  logic [N_LANES-1:0]          lane_out_val,
  input  logic [ITER_W*N_LANES-1:0]   lane_iter_count,
  output logic [N_LANES-1:0]          lane_out_rdy,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [ITER_W-1:0]           wr_data,
  input  logic                        wr_rdy
);

  state_t             state;
  logic [FIX_W-1:0]   x_start_q, dx_q, dy_q;
  logic [FIX_W-1:0]   cur_r, cur_i;
  logic [ADDR_W-1:0]  x, y, addr;
  logic [N_LANES-1:0] lane_busy;
  logic [ADDR_W-1:0]  tag [N_LANES];
  logic [N_LANES-1:0] disp, req, grant, collect;
  logic               disp_found;
  logic               row_end, last_pix;

  assign row_end  = (x == ADDR_W'(H_RES - 1));
  assign last_pix = row_end && (y == ADDR_W'(V_RES - 1));

  // Lowest free lane wins; a lane collected this cycle is still marked busy until the edge.
  always_comb begin
    disp       = '0;
    disp_found = 1'b0;
    if (state == RUN) begin
      for (int k = 0; k < N_LANES; k++) begin
        if (!disp_found && lane_in_rdy[k] && !lane_busy[k]) begin
          disp[k]    = 1'b1;
          disp_found = 1'b1;
        end
      end
    end
  end

  assign lane_in_val = disp;

  always_comb begin
    lane_c_r = '0;
    lane_c_i = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (disp[k]) begin
        lane_c_r[FIX_W*k +: FIX_W] = cur_r;
        lane_c_i[FIX_W*k +: FIX_W] = cur_i;
      end
    end
  end

  assign req = lane_out_val & lane_busy;

  rr_arbiter #(
    .N(N_LANES)
  ) u_collect_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .accept (wr_rdy),
    .grant  (grant)
  );

  assign collect      = wr_rdy ? grant : '0;
  assign lane_out_rdy = collect;
  assign wr_en        = |collect;

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    for (int j = 0; j < N_LANES; j++) begin
      if (collect[j]) begin
        wr_addr = tag[j];
        wr_data = lane_iter_count[ITER_W*j +: ITER_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      lane_busy <= '0;
      x_start_q <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      cur_r     <= '0;
      cur_i     <= '0;
      x         <= '0;
      y         <= '0;
      addr      <= '0;
      for (int k = 0; k < N_LANES; k++) tag[k] <= '0;
    end else begin
      done      <= 1'b0;
      lane_busy <= (lane_busy & ~collect) | disp;
      for (int k = 0; k < N_LANES; k++) begin
        if (disp[k]) tag[k] <= addr;
      end
      case (state)
        IDLE: begin
          if (start) begin
            x_start_q <= x_start;
            dx_q      <= dx;
            dy_q      <= dy;
            cur_r     <= x_start;
            cur_i     <= y_start;
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (disp_found) begin
            addr <= addr + ADDR_W'(1);
            // Imaginary part walks downward one row at a time.
            if (row_end) begin
              x     <= '0;
              y     <= y + ADDR_W'(1);
              cur_r <= x_start_q;
              cur_i <= cur_i - dy_q;
            end else begin
              x     <= x + ADDR_W'(1);
              cur_r <= cur_r + dx_q;
            end
            if (last_pix) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((lane_busy & ~collect) == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_scheduler.sv
// Directed bench for mandel_scheduler: behavioural lanes with fixed latency, 3x2 frame, 4 lanes.
module tb_mandel_scheduler;

  localparam int NL   = 4;
  localparam int H    = 3;
  localparam int V    = 2;
  localparam int AW   = 19;
  localparam int IW   = 11;
  localparam int NPIX = H * V;

  logic              clk = 1'b0;
  logic              reset, start, wr_rdy;
  logic [26:0]       x_start, y_start, dx, dy;
  logic              busy, done, wr_en;
  logic [NL-1:0]     lane_in_val, lane_in_rdy, lane_out_val, lane_out_rdy;
  logic [27*NL-1:0]  lane_c_r, lane_c_i;
  logic [IW*NL-1:0]  lane_iter_count;
  logic [AW-1:0]     wr_addr;
  logic [IW-1:0]     wr_data;

  always #5 clk = ~clk;

  mandel_scheduler #(
    .N_LANES(NL), .H_RES(H), .V_RES(V), .ADDR_W(AW), .ITER_W(IW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .x_start(x_start), .y_start(y_start), .dx(dx), .dy(dy),
    .busy(busy), .done(done),
    .lane_in_val(lane_in_val), .lane_c_r(lane_c_r), .lane_c_i(lane_c_i),
    .lane_in_rdy(lane_in_rdy), .lane_out_val(lane_out_val),
    .lane_iter_count(lane_iter_count), .lane_out_rdy(lane_out_rdy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Escape-time count in 4.23 fixed point, z <- z^2 + c until |z|^2 > 4 or 1000 iterations.
  function automatic int mandel(input logic [26:0] cr, input logic [26:0] ci);
    longint r, i, zr, zi, t;
    int n;
    r  = longint'($signed(cr));
    i  = longint'($signed(ci));
    zr = 0;
    zi = 0;
    n  = 0;
    while (n < 1000 && (zr * zr + zi * zi) <= (longint'(4) <<< 46)) begin
      t  = ((zr * zr - zi * zi) >>> 23) + r;
      zi = ((2 * zr * zi) >>> 23) + i;
      zr = t;
      n++;
    end
    return n;
  endfunction

  logic [26:0] cfg_xs, cfg_ys, cfg_dx, cfg_dy;

  function automatic logic [26:0] exp_cr(input int n);
    return cfg_xs + 27'(n % H) * cfg_dx;
  endfunction

  function automatic logic [26:0] exp_ci(input int n);
    return cfg_ys - 27'(n / H) * cfg_dy;
  endfunction

  // Behavioural lanes: lane k returns its result lat_base+k cycles after dispatch.
  logic [NL-1:0] lbusy;
  int            lcnt [NL];
  logic [IW-1:0] lres [NL];
  int            lat_base = 2;
  int            cyc = 0;

  always_comb begin
    lane_in_rdy     = '0;
    lane_out_val    = '0;
    lane_iter_count = '0;
    for (int k = 0; k < NL; k++) begin
      lane_in_rdy[k]               = !lbusy[k];
      lane_out_val[k]              = lbusy[k] && (lcnt[k] == 0);
      lane_iter_count[IW*k +: IW]  = lres[k];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      lbusy <= '0;
      for (int k = 0; k < NL; k++) begin
        lcnt[k] <= 0;
        lres[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NL; k++) begin
        if (lane_in_val[k] && lane_in_rdy[k]) begin
          lbusy[k] <= 1'b1;
          lcnt[k]  <= lat_base + k;
          lres[k]  <= IW'(mandel(lane_c_r[27*k +: 27], lane_c_i[27*k +: 27]));
        end else if (lane_out_val[k] && lane_out_rdy[k]) begin
          lbusy[k] <= 1'b0;
        end else if (lbusy[k] && lcnt[k] > 0) begin
          lcnt[k] <= lcnt[k] - 1;
        end
      end
    end
  end

  int          n_disp, n_wr, n_done, max_busy, last_wr_cyc, done_cyc, mk;
  int          wr_cnt [NPIX];
  logic [IW-1:0] wr_val [NPIX];
  logic [26:0] disp_cr [NPIX];
  logic [26:0] disp_ci [NPIX];

  always @(negedge clk) begin
    if (!reset) begin
      if (lane_in_val != '0) begin
        check_val("disp_onehot", $countones(lane_in_val), 1);
        mk = 0;
        for (int k = 0; k < NL; k++) if (lane_in_val[k]) mk = k;
        check_val("disp_lane_free", lane_in_rdy[mk], 1);
        if (n_disp < NPIX) begin
          disp_cr[n_disp] = lane_c_r[27*mk +: 27];
          disp_ci[n_disp] = lane_c_i[27*mk +: 27];
          check_val("disp_c_r", disp_cr[n_disp], exp_cr(n_disp));
          check_val("disp_c_i", disp_ci[n_disp], exp_ci(n_disp));
        end else begin
          check_val("disp_overrun", n_disp, NPIX - 1);
        end
        n_disp++;
      end
      if (!wr_rdy) begin
        check_val("hold_wr_en", wr_en, 0);
        check_val("hold_lane_out_rdy", lane_out_rdy, 0);
      end
      if (wr_en) begin
        check_val("wr_addr_range", wr_addr < AW'(NPIX), 1);
        if (wr_addr < AW'(NPIX)) begin
          wr_cnt[wr_addr]++;
          wr_val[wr_addr] = wr_data;
          check_val("wr_data", wr_data, IW'(mandel(exp_cr(int'(wr_addr)), exp_ci(int'(wr_addr)))));
        end
        n_wr++;
        last_wr_cyc = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if ($countones(lbusy) > max_busy) max_busy = $countones(lbusy);
    end
  end

  task automatic set_cfg(input logic [26:0] xs, ys, sdx, sdy, input int lat);
    cfg_xs = xs; cfg_ys = ys; cfg_dx = sdx; cfg_dy = sdy;
    x_start = xs; y_start = ys; dx = sdx; dy = sdy;
    lat_base = lat;
    n_disp = 0; n_wr = 0; n_done = 0; max_busy = 0;
    last_wr_cyc = -1; done_cyc = -1;
    for (int a = 0; a < NPIX; a++) begin
      wr_cnt[a] = 0;
      wr_val[a] = '0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_lane_in_val"}, lane_in_val, 0);
    check_val({tag, "_lane_out_rdy"}, lane_out_rdy, 0);
    check_val({tag, "_wr_en"}, wr_en, 0);
    check_val({tag, "_wr_addr"}, wr_addr, 0);
    check_val({tag, "_wr_data"}, wr_data, 0);
  endtask

  task automatic run_frame(input logic [26:0] xs, ys, sdx, sdy,
                           input int lat, input int hold_at, input int restart_at);
    int t, hold_wr, once;
    set_cfg(xs, ys, sdx, sdy, lat);
    hold_wr = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("busy_after_start", busy, 1);
    check_val("first_disp_lane0", lane_in_val, 1);
    t = 1;
    while (n_done == 0 && t < 3000) begin
      if (t == restart_at) begin
        x_start = 27'h1234567;
        dx      = 27'h0000001;
        start   = 1'b1;
      end
      if (t == hold_at) begin
        wr_rdy  = 1'b0;
        hold_wr = n_wr;
      end
      @(posedge clk); #1;
      start = 1'b0;
      t++;
      if (hold_at > 0 && t == hold_at + 50) begin
        check_val("hold_no_writes", n_wr, hold_wr);
        check_val("hold_disp_stall", n_disp, NL);
        check_val("hold_all_busy", $countones(lbusy), NL);
        wr_rdy = 1'b1;
      end
    end
    if (n_done == 0) check_val("frame_done_timeout", n_done, 1);
    repeat (3) @(posedge clk);
    #1;
    check_val("done_once", n_done, 1);
    check_val("write_count", n_wr, NPIX);
    once = 0;
    for (int a = 0; a < NPIX; a++) if (wr_cnt[a] == 1) once++;
    check_val("addr_written_once", once, NPIX);
    check_val("done_after_last_wr", done_cyc, last_wr_cyc + 1);
    check_val("idle_after_frame", busy, 0);
  endtask

  int exp_b [NPIX] = '{1, 3, 1000, 1000, 1000, 1000};
  int n_sat, w;

  initial begin
    reset = 1'b1; start = 1'b0; wr_rdy = 1'b1;
    x_start = '0; y_start = '0; dx = '0; dy = '0;
    set_cfg('0, '0, '0, '0, 2);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle_outputs("reset");

    // Real axis from -2.0 in 0.5 steps.
    run_frame(27'h7000000, 27'h0000000, 27'h0400000, 27'h0000000, 3, 0, 0);
    check_val("pix1_c_r", disp_cr[1], 27'h7400000);
    n_sat = 0;
    for (int a = 0; a < NPIX; a++) if (wr_val[a] == IW'(1000)) n_sat++;
    check_val("frame_a_all_1000", n_sat, NPIX);

    // Unit steps with a falling imaginary part exercise the row wrap.
    run_frame(27'h7000000, 27'h0800000, 27'h0800000, 27'h0800000, 2, 0, 0);
    check_val("wrap_x2_c_r", disp_cr[2], 27'h0000000);
    check_val("wrap_row1_c_r", disp_cr[3], 27'h7000000);
    check_val("wrap_row1_c_i", disp_ci[3], 27'h0000000);
    check_val("row0_c_i", disp_ci[0], 27'h0800000);
    for (int a = 0; a < NPIX; a++) check_val("frame_b_hand_data", wr_val[a], exp_b[a]);

    run_frame('0, '0, '0, '0, 8, 0, 0);
    check_val("zero_all_lanes_busy", max_busy, NL);
    n_sat = 0;
    for (int a = 0; a < NPIX; a++) if (wr_val[a] == IW'(1000)) n_sat++;
    check_val("zero_all_1000", n_sat, NPIX);

    run_frame(27'h7000000, 27'h0800000, 27'h0800000, 27'h0800000, 3, 3, 0);

    // Mid-frame reset with three lanes in flight.
    set_cfg(27'h7000000, 27'h0800000, 27'h0800000, 27'h0800000, 20);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while ($countones(lbusy) < 3 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_val("reset_wait_3busy", $countones(lbusy), 3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle_outputs("midreset");
    run_frame(27'h7000000, 27'h0800000, 27'h0800000, 27'h0800000, 1, 0, 0);

    // Second start while busy must not disturb the latched coordinates.
    run_frame(27'h7000000, 27'h0000000, 27'h0400000, 27'h0000000, 2, 0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
